mod_exp_engine: RTL and testbench

Parametrised modular exponentiation engine computing `result = base^exponent mod modulus` with a single shared bit-serial interleaved modular multiplier. It is the next-generation core for the RSA datapath: the control layer loads a key, pulses `start`, and collects the result on `done`. Compared with the fixed-flow encrypt/decrypt core it adds:

- a width parameter;
- a start/busy/done handshake;
- operand pre-reduction, so base ≥ modulus is legal;
- data-dependent early termination;
- a modulus-zero error flag.

---
 rtl/mod_exp_engine_if.sv | 24 ++
 rtl/mod_exp_engine.sv | 191 +++++++++++++++++++
 tb/tb_mod_exp_engine.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mod_exp_engine_if.sv
// Handshake and operand bus for mod_exp_engine: the requester drives start and
// the operands, the engine returns busy/done and the held result/error pair.
interface mod_exp_engine_if #(
    parameter int unsigned WIDTH = 128
);
    logic             start;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] exponent;
    logic [WIDTH-1:0] modulus;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             error;

    modport master (
        output start, base, exponent, modulus,
        input  busy, done, result, error
    );

    modport slave (
        input  start, base, exponent, modulus,
        output busy, done, result, error
    );
endinterface

// File: rtl/mod_exp_engine.sv
// Modular exponentiation engine: result = base^exponent mod modulus.
// Right-to-left square-and-multiply around one bit-serial interleaved modular
// multiplier (one multiplier bit per cycle, WIDTH cycles per product).
module mod_exp_engine #(
    parameter int unsigned WIDTH = 128
) (
    input  logic              clk,
    input  logic              reset,
    mod_exp_engine_if.slave   bus
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REDUCE,
        S_CHECK,
        S_MUL_R,
        S_MUL_B,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic [WIDTH-1:0] e_q, e_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             error_q, error_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             mul_abit;
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH:0]   mul_m;
    logic [WIDTH:0]   mul_dbl;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_out;
    logic             mul_active;
    logic             mul_last;

    // One multiplier step: acc = 2*acc mod m, then conditionally add b mod m.
    always_comb begin
        mul_abit   = 1'b0;
        mul_b      = '0;
        mul_active = 1'b0;
        case (state_q)
            S_REDUCE: begin
                mul_abit   = base_q[cnt_q];
                mul_b      = WIDTH'(1);
                mul_active = 1'b1;
            end
            S_MUL_R: begin
                mul_abit   = r_q[cnt_q];
                mul_b      = b_q;
                mul_active = 1'b1;
            end
            S_MUL_B: begin
                mul_abit   = b_q[cnt_q];
                mul_b      = b_q;
                mul_active = 1'b1;
            end
            default: ;
        endcase
        mul_m   = {1'b0, m_q};
        mul_dbl = {acc_q[WIDTH-1:0], 1'b0};
        if (mul_dbl >= mul_m) begin
            mul_dbl = mul_dbl - mul_m;
        end
        mul_sum = mul_dbl;
        if (mul_abit) begin
            mul_sum = mul_dbl + {1'b0, mul_b};
        end
        if (mul_sum >= mul_m) begin
            mul_sum = mul_sum - mul_m;
        end
        mul_out  = mul_sum[WIDTH-1:0];
        mul_last = (cnt_q == '0);
    end

    // Sequencing of reduce / check / multiply / square and job acceptance.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        e_d      = e_q;
        m_d      = m_q;
        r_d      = r_q;
        b_d      = b_q;
        result_d = result_q;
        error_d  = error_q;
        acc_d    = '0;
        cnt_d    = CNT_TOP;

        // The accumulator and bit counter rearm on the last step so that a
        // multiply may follow another multiply with no idle cycle between.
        if (mul_active && !mul_last) begin
            acc_d = mul_sum;
            cnt_d = cnt_q - CW'(1);
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    base_d = bus.base;
                    e_d    = bus.exponent;
                    m_d    = bus.modulus;
                    if (bus.modulus == '0) begin
                        state_d  = S_DONE;
                        error_d  = 1'b1;
                        result_d = '0;
                    end else begin
                        state_d = S_REDUCE;
                        error_d = 1'b0;
                        r_d     = (bus.modulus == WIDTH'(1)) ? '0 : WIDTH'(1);
                    end
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_REDUCE: begin
                if (mul_last) begin
                    b_d     = mul_out;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (e_q == '0) begin
                    state_d  = S_DONE;
                    result_d = r_q;
                end else if (e_q[0]) begin
                    state_d = S_MUL_R;
                end else begin
                    state_d = S_MUL_B;
                end
            end
            S_MUL_R: begin
                if (mul_last) begin
                    r_d = mul_out;
                    // Top exponent bit consumed: the final squaring is skipped.
                    if ((e_q >> 1) == '0) begin
                        state_d  = S_DONE;
                        result_d = mul_out;
                    end else begin
                        state_d = S_MUL_B;
                    end
                end
            end
            S_MUL_B: begin
                if (mul_last) begin
                    b_d     = mul_out;
                    e_d     = e_q >> 1;
                    state_d = S_CHECK;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            e_q      <= '0;
            m_q      <= '0;
            r_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            e_q      <= e_d;
            m_q      <= m_d;
            r_q      <= r_d;
            b_q      <= b_d;
            result_q <= result_d;
            error_q  <= error_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.busy   = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = result_q;
    assign bus.error  = error_q;
endmodule

// File: tb/tb_mod_exp_engine.sv
// Self-checking bench for mod_exp_engine: reference model in plain arithmetic,
// per-cycle compare of the 16-bit instance, plus chained RSA and a 128-bit job.
`timescale 1ns/1ps
module tb_mod_exp_engine;
    localparam int unsigned W     = 16;
    localparam int unsigned WB    = 128;
    localparam int unsigned LIMIT = 2 * W * W + W + 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    bit          chk_en  = 1'b0;

    mod_exp_engine_if #(.WIDTH(W)) u_if ();
    mod_exp_engine #(.WIDTH(W)) u_dut (.clk(clk), .reset(reset), .bus(u_if));

    mod_exp_engine_if #(.WIDTH(WB)) big_if ();
    mod_exp_engine #(.WIDTH(WB)) u_big (.clk(clk), .reset(reset), .bus(big_if));

    mod_exp_engine_if #(.WIDTH(W)) enc_if ();
    mod_exp_engine_if #(.WIDTH(W)) dec_if ();
    mod_exp_engine #(.WIDTH(W)) u_enc (.clk(clk), .reset(reset), .bus(enc_if));
    mod_exp_engine #(.WIDTH(W)) u_dec (.clk(clk), .reset(reset), .bus(dec_if));

    assign dec_if.start    = enc_if.done;
    assign dec_if.base     = enc_if.result;
    assign dec_if.exponent = 16'd2753;
    assign dec_if.modulus  = 16'd3233;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] mexp(input logic [127:0] b, input logic [127:0] e,
                                          input logic [127:0] m);
        logic [255:0] r, x, mm;
        if (m == '0) return '0;
        mm = {128'b0, m};
        r  = 256'd1 % mm;
        x  = {128'b0, b} % mm;
        for (int i = 0; i < 128; i++) begin
            if (e[i]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return r[127:0];
    endfunction

    function automatic int unsigned ncyc(input logic [127:0] e, input logic [127:0] m,
                                         input int unsigned w);
        int unsigned bl, k;
        if (m == '0) return 1;
        if (e == '0) return w + 2;
        bl = 0;
        k  = 0;
        for (int i = 0; i < 128; i++) begin
            if (e[i]) begin
                k++;
                bl = unsigned'(i + 1);
            end
        end
        return w * (k + bl) + bl + 1;
    endfunction

    function automatic logic [255:0] modinv(input logic [255:0] a, input logic [255:0] n);
        logic [255:0] r0, r1, s0, s1, q, t;
        r0 = n;
        r1 = a % n;
        s0 = '0;
        s1 = 256'd1;
        while (r1 != '0) begin
            q  = r0 / r1;
            t  = r0 - q * r1;
            r0 = r1;
            r1 = t;
            t  = (s0 + n - (q * s1) % n) % n;
            s0 = s1;
            s1 = t;
        end
        return s0;
    endfunction

    // Reference model of the 16-bit instance: job timing and held outputs.
    logic            m_active = 1'b0;
    int unsigned     m_cyc    = 0;
    int unsigned     m_n      = 0;
    logic [W-1:0]    m_res    = '0;
    logic            m_err    = 1'b0;
    logic [W-1:0]    held_res = '0;
    logic            held_err = 1'b0;

    initial begin
        logic [127:0] r128;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_active = 1'b0;
                held_res = '0;
                held_err = 1'b0;
            end else if (u_if.start && !(m_active && m_cyc < m_n)) begin
                r128     = mexp(128'(u_if.base), 128'(u_if.exponent), 128'(u_if.modulus));
                m_res    = r128[W-1:0];
                m_err    = (u_if.modulus == '0);
                m_n      = ncyc(128'(u_if.exponent), 128'(u_if.modulus), W);
                m_cyc    = 1;
                m_active = 1'b1;
                if (!m_err) held_err = 1'b0;
                if (m_n == 1) begin
                    held_res = m_res;
                    held_err = m_err;
                end
            end else if (m_active && m_cyc < m_n) begin
                m_cyc++;
                if (m_cyc == m_n) begin
                    held_res = m_res;
                    held_err = m_err;
                end
            end else begin
                m_active = 1'b0;
            end
        end
    end

    // Compare the 16-bit instance against the model every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("busy",   128'(u_if.busy),   128'(m_active && m_cyc < m_n));
                check("done",   128'(u_if.done),   128'(m_active && m_cyc == m_n));
                check("result", 128'(u_if.result), 128'(held_res));
                check("error",  128'(u_if.error),  128'(held_err));
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Runs one job on the 16-bit instance; returns in its DONE cycle.
    task automatic run_job(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m,
                           input logic [W-1:0] exp_res, input logic exp_err,
                           input int unsigned exp_n, input bit disturb, input string tag);
        int unsigned cyc;
        bit          seen;
        cyc  = 0;
        seen = 1'b0;
        u_if.base     = b;
        u_if.exponent = e;
        u_if.modulus  = m;
        u_if.start    = 1'b1;
        for (int i = 0; i < int'(LIMIT); i++) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                u_if.start = 1'b0;
                if (m != '0) check({tag, " error@cycle1"}, 128'(u_if.error), 128'(0));
            end
            if (disturb && cyc == 10) begin
                u_if.start    = 1'b1;
                u_if.base     = W'($urandom);
                u_if.exponent = W'($urandom);
                u_if.modulus  = W'($urandom);
            end
            if (disturb && cyc == 11) u_if.start = 1'b0;
            if (u_if.done) begin
                seen = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s timeout: no done within %0d cycles, required done", tag, LIMIT);
        end
        check({tag, " done cycle"}, 128'(cyc), 128'(exp_n));
        check({tag, " result"}, 128'(u_if.result), 128'(exp_res));
        check({tag, " error"}, 128'(u_if.error), 128'(exp_err));
    endtask

    initial begin
        logic [W-1:0]  rb, re, rm, msg16, er;
        logic [127:0]  r128, p, q, n, phi, d, big_msg, ct, bexp, bbase;
        logic [255:0]  t256;
        int unsigned   cyc;
        bit            seen;

        reset = 1'b1;
        u_if.start = 1'b0; u_if.base = '0; u_if.exponent = '0; u_if.modulus = '0;
        big_if.start = 1'b0; big_if.base = '0; big_if.exponent = '0; big_if.modulus = '0;
        enc_if.start = 1'b0; enc_if.base = '0; enc_if.exponent = '0; enc_if.modulus = '0;
        repeat (3) @(negedge clk);
        check("reset busy",   128'(u_if.busy),   128'(0));
        check("reset done",   128'(u_if.done),   128'(0));
        check("reset result", 128'(u_if.result), 128'(0));
        check("reset error",  128'(u_if.error),  128'(0));
        chk_en = 1'b1;
        reset  = 1'b0;

        // Hand-computed values pinning the model.
        check("model 4^13%497",       mexp(128'd4, 128'd13, 128'd497), 128'd445);
        check("model 65^17%3233",     mexp(128'd65, 128'd17, 128'd3233), 128'd2790);
        check("model 2790^2753%3233", mexp(128'd2790, 128'd2753, 128'd3233), 128'd65);
        check("model 1000^1%497",     mexp(128'd1000, 128'd1, 128'd497), 128'd6);
        check("model 3^65520%65521",  mexp(128'd3, 128'd65520, 128'd65521), 128'd1);
        check("model N 4^13",         128'(ncyc(128'd13, 128'd497, W)), 128'd117);
        check("model N e=0",          128'(ncyc(128'd0, 128'd497, W)), 128'd18);
        check("model N e=1",          128'(ncyc(128'd1, 128'd497, W)), 128'd34);

        // Directed jobs, mostly back-to-back from the DONE cycle.
        @(negedge clk);
        run_job(16'd4,    16'd13,    16'd497,   16'd445,  1'b0, 117, 1'b0, "4^13");
        run_job(16'd65,   16'd17,    16'd3233,  16'd2790, 1'b0, 118, 1'b0, "rsa enc");
        run_job(16'd2790, 16'd2753,  16'd3233,  16'd65,   1'b0, 285, 1'b0, "rsa dec");
        @(negedge clk);
        run_job(16'd7,    16'd0,     16'd497,   16'd1,    1'b0, 18,  1'b0, "exp0");
        run_job(16'd5,    16'd3,     16'd1,     16'd0,    1'b0, 67,  1'b0, "mod1");
        run_job(16'd1000, 16'd1,     16'd497,   16'd6,    1'b0, 34,  1'b0, "prereduce");
        run_job(16'd123,  16'd45,    16'd0,     16'd0,    1'b1, 1,   1'b0, "mod0");
        run_job(16'd3,    16'd65520, 16'd65521, 16'd1,    1'b0, 465, 1'b0, "fermat");
        @(negedge clk);
        run_job(16'd1000, 16'd1,     16'd497,   16'd6,    1'b0, 34,  1'b0, "prereduce2");
        @(negedge clk);

        // Reset in cycle 40 of a running job.
        u_if.base = 16'd4; u_if.exponent = 16'd13; u_if.modulus = 16'd497; u_if.start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) u_if.start = 1'b0;
            if (c == 40) reset = 1'b1;
        end
        @(negedge clk);
        check("midjob reset busy",   128'(u_if.busy),   128'(0));
        check("midjob reset done",   128'(u_if.done),   128'(0));
        check("midjob reset result", 128'(u_if.result), 128'(0));
        check("midjob reset error",  128'(u_if.error),  128'(0));
        reset = 1'b0;
        run_job(16'd4, 16'd13, 16'd497, 16'd445, 1'b0, 117, 1'b1, "after reset");
        @(negedge clk);

        // Randomized jobs checked against the model.
        for (int t = 0; t < 30; t++) begin
            rb = W'($urandom);
            re = W'($urandom);
            rm = W'($urandom);
            case ($urandom_range(5, 0))
                0: re = W'($urandom_range(3, 0));
                1: rm = W'($urandom_range(2, 0));
                2: re = '1;
                default: ;
            endcase
            r128 = mexp(128'(rb), 128'(re), 128'(rm));
            er   = r128[W-1:0];
            run_job(rb, re, rm, er, (rm == '0), ncyc(128'(re), 128'(rm), W), 1'b0, "random");
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end

        // Chained encrypt/decrypt instances must return the plaintext.
        for (int r = 0; r < 8; r++) begin
            msg16 = W'($urandom_range(3232, 0));
            @(negedge clk);
            enc_if.base = msg16; enc_if.exponent = 16'd17; enc_if.modulus = 16'd3233;
            enc_if.start = 1'b1;
            @(negedge clk);
            enc_if.start = 1'b0;
            seen = 1'b0;
            for (int i = 0; i < 2000; i++) begin
                @(negedge clk);
                if (dec_if.done) begin
                    seen = 1'b1;
                    break;
                end
            end
            n_tests++;
            if (!seen) begin
                n_fail++;
                $display("FAIL chain timeout: no decrypt done, required done");
            end
            r128 = mexp(128'(msg16), 128'd17, 128'd3233);
            check("chain ciphertext", 128'(enc_if.result), r128);
            check("chain roundtrip",  128'(dec_if.result), 128'(msg16));
        end

        // 128-bit RSA encrypt then decrypt.
        p       = 128'd113680897410347;
        q       = 128'd7999808077935876437321;
        n       = p * q;
        phi     = (p - 128'd1) * (q - 128'd1);
        t256    = modinv(256'd65537, {128'b0, phi});
        d       = t256[127:0];
        t256    = ({128'b0, d} * 256'd65537) % {128'b0, phi};
        check("model d*e mod phi", t256[127:0], 128'd1);
        big_msg = 128'h00262d806a3e18f03ab37b2857e7e149;
        ct      = '0;
        for (int j = 0; j < 2; j++) begin
            bbase = (j == 0) ? big_msg : ct;
            bexp  = (j == 0) ? 128'd65537 : d;
            @(negedge clk);
            big_if.base = bbase; big_if.exponent = bexp; big_if.modulus = n;
            big_if.start = 1'b1;
            cyc  = 0;
            seen = 1'b0;
            for (int i = 0; i < 40000; i++) begin
                @(negedge clk);
                cyc++;
                if (cyc == 1) big_if.start = 1'b0;
                if (big_if.done) begin
                    seen = 1'b1;
                    break;
                end
            end
            n_tests++;
            if (!seen) begin
                n_fail++;
                $display("FAIL big%0d timeout: no done within 40000 cycles, required done", j);
            end
            r128 = mexp(bbase, bexp, n);
            check("big result", big_if.result, r128);
            check("big done cycle", 128'(cyc), 128'(ncyc(bexp, n, WB)));
            check("big error", 128'(big_if.error), 128'(0));
            if (j == 0) ct = r128;
            else check("big roundtrip", big_if.result, big_msg);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
